// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: instruction memory request/ack and the
// valid/ready instruction hand-off with next-PC selection.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        instr_ready;
    logic [1:0]  pc_src;
    logic [31:0] branch_target;
    logic [31:0] jalr_target;
    logic        misalign_err;

    modport master (
        output imem_req, imem_addr, instr, pc, pc_plus4,
        output instr_valid, misalign_err,
        input  imem_ack, imem_rdata, instr_ready, pc_src,
        input  branch_target, jalr_target
    );

    modport slave (
        input  imem_req, imem_addr, instr, pc, pc_plus4,
        input  instr_valid, misalign_err,
        output imem_ack, imem_rdata, instr_ready, pc_src,
        output branch_target, jalr_target
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, fetches over req/ack and hands the
// instruction to the decoder; misaligned next-PC halts fetch.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input logic                clk,
    input logic                reset,
    instr_fetch_unit_if.master bus
);
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        HOLD = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        req_q, req_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [31:0] npc;
    logic        unused_jalr_lsb;

    assign unused_jalr_lsb = bus.jalr_target[0];

    always_comb begin
        case (bus.pc_src)
            2'b01:   npc = bus.branch_target;
            2'b10:   npc = {bus.jalr_target[31:1], 1'b0};
            default: npc = pc_q + 32'd4;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        req_d   = req_q;
        valid_d = valid_q;
        err_d   = err_q;
        unique case (state_q)
            REQ: begin
                // req is low only in the first cycle out of reset
                if (!req_q) begin
                    req_d = 1'b1;
                end else if (bus.imem_ack) begin
                    instr_d = bus.imem_rdata;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.instr_ready) begin
                    valid_d = 1'b0;
                    if (npc[1:0] != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = ERR;
                    end else begin
                        pc_d    = npc;
                        instr_d = NOP_INSTR;
                        req_d   = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            ERR: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
                err_d   = 1'b1;
            end
            default: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
                err_d   = 1'b1;
                state_d = ERR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign bus.imem_req     = req_q;
    assign bus.imem_addr    = pc_q;
    assign bus.instr        = instr_q;
    assign bus.pc           = pc_q;
    assign bus.pc_plus4     = pc_q + 32'd4;
    assign bus.instr_valid  = valid_q;
    assign bus.misalign_err = err_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random traffic
// checked every cycle against a transaction-level reference model.
module tb_instr_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_fail = 0;

    instr_fetch_unit_if bus();

    instr_fetch_unit #(
        .RESET_PC (RST_PC),
        .NOP_INSTR(NOP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference model: tracks what the fetch stage must show,
    // derived from whether an instruction is held and the error flag.
    logic [31:0] m_pc, m_instr;
    logic        m_valid, m_req, m_err;
    bit          m_live = 0;

    always @(posedge clk) begin
        logic [31:0] npc;
        if (reset) begin
            m_live  = 1;
            m_pc    = RST_PC;
            m_instr = NOP;
            m_valid = 0;
            m_req   = 0;
            m_err   = 0;
        end else if (m_live && !m_err) begin
            if (!m_valid) begin
                if (!m_req) m_req = 1;
                else if (bus.imem_ack) begin
                    m_instr = bus.imem_rdata;
                    m_valid = 1;
                    m_req   = 0;
                end
            end else if (bus.instr_ready) begin
                if (bus.pc_src == 2'b01) npc = bus.branch_target;
                else if (bus.pc_src == 2'b10) npc = bus.jalr_target & ~32'd1;
                else npc = m_pc + 32'd4;
                m_valid = 0;
                if (npc % 4 != 0) m_err = 1;
                else begin
                    m_pc    = npc;
                    m_instr = NOP;
                    m_req   = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("imem_req", 32'(bus.imem_req), 32'(m_req));
            chk("imem_addr", bus.imem_addr, m_pc);
            chk("pc", bus.pc, m_pc);
            chk("pc_plus4", bus.pc_plus4, m_pc + 32'd4);
            chk("instr", bus.instr, m_instr);
            chk("instr_valid", 32'(bus.instr_valid), 32'(m_valid));
            chk("misalign_err", 32'(bus.misalign_err), 32'(m_err));
        end
    end

    task automatic fetch(input int nwait, input logic [31:0] data);
        int n = 0;
        bus.imem_ack = 0;
        while (!bus.imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            n_chk++;
            n_fail++;
            $display("FAIL fetch_timeout: no imem_req within 20 cycles");
        end
        repeat (nwait) @(negedge clk);
        bus.imem_ack   = 1;
        bus.imem_rdata = data;
        @(negedge clk);
        bus.imem_ack   = 0;
        bus.imem_rdata = $urandom();
    endtask

    task automatic retire(input logic [1:0] src, input logic [31:0] bt,
                          input logic [31:0] jt);
        bus.instr_ready   = 1;
        bus.pc_src        = src;
        bus.branch_target = bt;
        bus.jalr_target   = jt;
        @(negedge clk);
        bus.instr_ready   = 0;
        bus.pc_src        = 2'($urandom());
        bus.branch_target = $urandom() | 32'd2;
        bus.jalr_target   = $urandom() | 32'd2;
    endtask

    task automatic do_reset();
        reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
    endtask

    initial begin
        logic [31:0] hold_i, hold_p, b, j;
        reset = 1;
        bus.imem_ack = 0;
        bus.imem_rdata = 0;
        bus.instr_ready = 0;
        bus.pc_src = 0;
        bus.branch_target = 0;
        bus.jalr_target = 0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_instr", bus.instr, NOP);
        chk("rst_err", 32'(bus.misalign_err), 32'd0);
        reset = 0;

        // 1: two wait states then ack
        fetch(2, 32'h0050_0093);
        chk("t1_valid", 32'(bus.instr_valid), 32'd1);
        chk("t1_instr", bus.instr, 32'h0050_0093);
        chk("t1_pc", bus.pc, 32'h0);
        chk("t1_pc4", bus.pc_plus4, 32'h4);

        // 2: consumer stalls 5 cycles
        hold_i = bus.instr;
        hold_p = bus.pc;
        for (int i = 0; i < 5; i++) begin
            bus.imem_ack = 1;
            @(negedge clk);
            chk("t2_instr", bus.instr, hold_i);
            chk("t2_pc", bus.pc, hold_p);
            chk("t2_req", 32'(bus.imem_req), 32'd0);
        end
        bus.imem_ack = 0;
        retire(2'b00, 0, 0);
        chk("t2_addr", bus.imem_addr, 32'h4);
        chk("t2_req1", 32'(bus.imem_req), 32'd1);

        // 3: branch and jalr
        fetch(0, 32'h0000_0063);
        retire(2'b01, 32'h40, 0);
        chk("t3_br", bus.imem_addr, 32'h40);
        fetch(1, 32'h0000_0067);
        retire(2'b10, 0, 32'h101);
        chk("t3_jalr", bus.imem_addr, 32'h100);
        chk("t3_err", 32'(bus.misalign_err), 32'd0);

        // 4: misaligned branch halts until reset
        fetch(0, 32'h0000_0063);
        retire(2'b01, 32'h42, 0);
        for (int i = 0; i < 10; i++) begin
            bus.imem_ack = 1'($urandom());
            bus.instr_ready = 1'($urandom());
            chk("t4_err", 32'(bus.misalign_err), 32'd1);
            chk("t4_valid", 32'(bus.instr_valid), 32'd0);
            chk("t4_req", 32'(bus.imem_req), 32'd0);
            @(negedge clk);
        end
        bus.imem_ack = 0;
        bus.instr_ready = 0;
        do_reset();
        chk("t4_clr", 32'(bus.misalign_err), 32'd0);

        // 5: wrap at top of address space
        fetch(0, 32'h0000_006f);
        retire(2'b01, 32'hFFFF_FFFC, 0);
        fetch(0, 32'h0000_0013);
        chk("t5_pc4", bus.pc_plus4, 32'h0);
        retire(2'b00, 0, 0);
        chk("t5_wrap", bus.imem_addr, 32'h0);
        chk("t5_err", 32'(bus.misalign_err), 32'd0);
        fetch(0, 32'h0000_0013);
        retire(2'b11, 32'h80, 32'h80);
        chk("t5_rsv", bus.imem_addr, 32'h4);

        // 6: reset during REQ with ack, then spurious ack
        chk("t6_pre", 32'(bus.imem_req), 32'd1);
        reset = 1;
        bus.imem_ack = 1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t6_valid", 32'(bus.instr_valid), 32'd0);
        chk("t6_req", 32'(bus.imem_req), 32'd0);
        reset = 0;
        @(negedge clk);
        chk("t6_spur", 32'(bus.instr_valid), 32'd0);
        chk("t6_addr", bus.imem_addr, RST_PC);
        fetch(1, 32'h0010_0113);
        chk("t6_instr", bus.instr, 32'h0010_0113);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            b = $urandom();
            j = $urandom();
            if ($urandom_range(0, 39) != 0) b[1:0] = 2'b00;
            if ($urandom_range(0, 39) != 0) j[1] = 1'b0;
            bus.imem_ack      = ($urandom_range(0, 2) == 0);
            bus.imem_rdata    = $urandom();
            bus.instr_ready   = ($urandom_range(0, 2) == 0);
            bus.pc_src        = 2'($urandom());
            bus.branch_target = b;
            bus.jalr_target   = j;
            reset = (m_err && $urandom_range(0, 7) == 0) ||
                    ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        reset = 0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
